rv_iommu_mrif_engine: RTL and testbench



---
 rtl/rv_iommu_mrif_engine.sv | 320 ++++++++++++++++++++++++++++++++
 tb/tb_rv_iommu_mrif_engine.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_iommu_mrif_engine.sv
// rtl/rv_iommu_mrif_engine.sv - MRIF interrupt-pending update and notice MSI engine
//
// Package rv_iommu: cause codes, AXI atomic encodings and the default AXI structs.
//
// Module rv_iommu_mrif_engine: sets the interrupt-pending (IP) bit of one identity in
// a memory-resident interrupt file and, if the matching interrupt-enable (IE) bit is
// set, sends the notice MSI.
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   mem_req_o / mem_resp_i      AXI request / response structs
//   init_mrif_i                 start request, sampled only in IDLE
//   int_id_i                    interrupt identity (MSI data)
//   mrif_addr_i                 MRIF base, 512-byte granule number
//   notice_nid_i, notice_ppn_i  notice MSI data and page
//   busy_o                      engine not in IDLE
//   done_o, ignore_o, error_o   one-cycle completion / discard / AXI error pulses
//   cause_o                     fault cause, valid with error_o

package rv_iommu;
  localparam int unsigned CAUSE_LEN = 12;
  localparam logic [CAUSE_LEN-1:0] MSI_PT_DATA_CORRUPTION = 12'd270;

  localparam logic [5:0] ATOP_ATOMICLOAD = 6'b10_0000;
  localparam logic [5:0] ATOP_SET        = 6'b00_0011;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [5:0]  atop;
  } axi_aw_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } axi_ar_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } axi_w_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } axi_b_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } axi_r_t;

  typedef struct packed {
    axi_aw_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ar_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    logic   b_valid;
    axi_b_t b;
    logic   r_valid;
    axi_r_t r;
  } axi_rsp_t;
endpackage

module rv_iommu_mrif_engine #(
  parameter type         axi_req_t  = rv_iommu::axi_req_t,
  parameter type         axi_rsp_t  = rv_iommu::axi_rsp_t,
  parameter int unsigned ID_BITS    = 11,
  parameter bit          USE_ATOMIC = 1'b0,
  parameter logic [3:0]  AR_ID      = 4'b0100,
  parameter logic [3:0]  AW_ID      = 4'b0011
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  axi_rsp_t                         mem_resp_i,
  output axi_req_t                         mem_req_o,
  input  logic                             init_mrif_i,
  input  logic [31:0]                      int_id_i,
  input  logic [46:0]                      mrif_addr_i,
  input  logic [10:0]                      notice_nid_i,
  input  logic [43:0]                      notice_ppn_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             ignore_o,
  output logic                             error_o,
  output logic [rv_iommu::CAUSE_LEN-1:0]   cause_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_IP_AR, S_IP_R, S_IP_WR, S_IP_B,
    S_AT_WR, S_AT_RSP, S_IE_AR, S_IE_R,
    S_NT_WR, S_NT_B, S_DRAIN
  } state_e;

  state_e      r_state;
  logic [10:0] r_id;
  logic [55:0] r_pptr;
  logic [63:0] r_ip;
  logic [63:0] r_ie;
  logic [43:0] r_nppn;
  logic [10:0] r_nnid;
  logic        r_beat;
  logic        r_aw_done;
  logic        r_w_done;
  logic        r_b_got;
  logic        r_r_got;
  logic        r_err;

  logic        w_id_ok;
  logic [10:0] w_id11;
  logic [63:0] w_mask;
  logic        w_ie_hit;
  logic        w_rd_hit;
  logic        w_wr_state;
  logic        w_ar_valid, w_aw_valid, w_w_valid, w_r_ready, w_b_ready;
  logic        w_ar_hs, w_aw_hs, w_w_hs, w_r_hs, w_b_hs;
  logic        w_r_err, w_b_err;
  logic        w_wr_fin;
  logic        w_at_b, w_at_r, w_at_err;
  logic        w_unused;

  // Identity 0 is reserved; bits above ID_BITS must be clear.
  assign w_id_ok  = ((int_id_i >> ID_BITS) == 32'd0) && (int_id_i != 32'd0);
  assign w_id11   = 11'(int_id_i[ID_BITS-1:0]);
  assign w_mask   = 64'd1 << r_id[5:0];
  assign w_ie_hit = |(r_ie & w_mask);
  assign w_rd_hit = |(mem_resp_i.r.data & w_mask);

  assign w_wr_state = (r_state == S_IP_WR) || (r_state == S_AT_WR) || (r_state == S_NT_WR);
  assign w_aw_valid = w_wr_state && !r_aw_done;
  assign w_w_valid  = w_wr_state && !r_w_done;
  assign w_ar_valid = (r_state == S_IP_AR) || (r_state == S_IE_AR);
  assign w_r_ready  = (r_state == S_IP_R) || (r_state == S_IE_R) || (r_state == S_DRAIN) ||
                      ((r_state == S_AT_RSP) && !r_r_got);
  assign w_b_ready  = (r_state == S_IP_B) || (r_state == S_NT_B) ||
                      ((r_state == S_AT_RSP) && !r_b_got);

  assign w_ar_hs = w_ar_valid && mem_resp_i.ar_ready;
  assign w_aw_hs = w_aw_valid && mem_resp_i.aw_ready;
  assign w_w_hs  = w_w_valid  && mem_resp_i.w_ready;
  assign w_r_hs  = w_r_ready  && mem_resp_i.r_valid;
  assign w_b_hs  = w_b_ready  && mem_resp_i.b_valid;
  assign w_r_err = mem_resp_i.r.resp != 2'b00;
  assign w_b_err = mem_resp_i.b.resp != 2'b00;

  // AW and W are issued together; each side may complete in a different cycle.
  assign w_wr_fin = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);

  // Atomic mode: B and the AtomicLoad R beat may arrive in either order.
  assign w_at_b   = r_b_got || w_b_hs;
  assign w_at_r   = r_r_got || w_r_hs;
  assign w_at_err = r_err || (w_r_hs && w_r_err) || (w_b_hs && w_b_err);

  assign busy_o   = (r_state != S_IDLE);
  assign ignore_o = (r_state == S_IDLE) && init_mrif_i && !w_id_ok;
  assign cause_o  = error_o ? rv_iommu::MSI_PT_DATA_CORRUPTION : '0;

  assign w_unused = ^{mem_resp_i.b.id, mem_resp_i.r.id, r_id[10:6], r_ip, r_beat};

  // Completion pulses coincide with the final handshake so that IDLE follows next cycle.
  always_comb begin
    done_o  = 1'b0;
    error_o = 1'b0;
    case (r_state)
      S_IP_R:   error_o = w_r_hs && w_r_err;
      S_IP_B: begin
        error_o = w_b_hs && w_b_err;
        done_o  = w_b_hs && !w_b_err && !w_ie_hit;
      end
      S_AT_RSP: error_o = !r_err && ((w_r_hs && w_r_err) || (w_b_hs && w_b_err));
      S_IE_R: begin
        error_o = w_r_hs && w_r_err;
        done_o  = w_r_hs && !w_r_err && !w_rd_hit;
      end
      S_NT_B: begin
        error_o = w_b_hs && w_b_err;
        done_o  = w_b_hs && !w_b_err;
      end
      default: ;
    endcase
  end

  // Payloads come only from registers, so they stay stable while a valid is held.
  always_comb begin
    mem_req_o          = '0;
    mem_req_o.aw_valid = w_aw_valid;
    mem_req_o.w_valid  = w_w_valid;
    mem_req_o.ar_valid = w_ar_valid;
    mem_req_o.r_ready  = w_r_ready;
    mem_req_o.b_ready  = w_b_ready;

    mem_req_o.aw.id    = AW_ID;
    mem_req_o.aw.burst = 2'b01;
    mem_req_o.aw.len   = 8'd0;
    mem_req_o.w.last   = 1'b1;
    if (r_state == S_NT_WR) begin
      mem_req_o.aw.addr = 64'({r_nppn, 12'b0});
      mem_req_o.aw.size = 3'd2;
      mem_req_o.w.data  = {32'b0, 21'b0, r_nnid};
      mem_req_o.w.strb  = 8'h0F;
    end else begin
      mem_req_o.aw.addr = 64'(r_pptr);
      mem_req_o.aw.size = 3'd3;
      mem_req_o.w.strb  = 8'hFF;
      if (USE_ATOMIC) begin
        mem_req_o.aw.atop = rv_iommu::ATOP_ATOMICLOAD | rv_iommu::ATOP_SET;
        mem_req_o.w.data  = w_mask;
      end else begin
        mem_req_o.w.data  = r_ip | w_mask;
      end
    end

    mem_req_o.ar.id    = AR_ID;
    mem_req_o.ar.size  = 3'd3;
    mem_req_o.ar.burst = 2'b01;
    if (USE_ATOMIC) begin
      mem_req_o.ar.addr = 64'(r_pptr) + 64'd8;
      mem_req_o.ar.len  = 8'd0;
    end else begin
      mem_req_o.ar.addr = 64'(r_pptr);
      mem_req_o.ar.len  = 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_id      <= '0;
      r_pptr    <= '0;
      r_ip      <= '0;
      r_ie      <= '0;
      r_nppn    <= '0;
      r_nnid    <= '0;
      r_beat    <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_b_got   <= 1'b0;
      r_r_got   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (init_mrif_i && w_id_ok) begin
            r_id      <= w_id11;
            r_pptr    <= {mrif_addr_i, w_id11[10:6], 4'b0};
            r_nppn    <= notice_ppn_i;
            r_nnid    <= notice_nid_i;
            r_beat    <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_b_got   <= 1'b0;
            r_r_got   <= 1'b0;
            r_err     <= 1'b0;
            r_state   <= USE_ATOMIC ? S_AT_WR : S_IP_AR;
          end
        end
        S_IP_AR: if (w_ar_hs) r_state <= S_IP_R;
        S_IP_R: begin
          if (w_r_hs) begin
            if (!r_beat) r_ip <= mem_resp_i.r.data;
            else         r_ie <= mem_resp_i.r.data;
            r_beat <= 1'b1;
            if (w_r_err)                r_state <= mem_resp_i.r.last ? S_IDLE : S_DRAIN;
            else if (mem_resp_i.r.last) r_state <= S_IP_WR;
          end
        end
        S_IP_WR, S_AT_WR, S_NT_WR: begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs)  r_w_done  <= 1'b1;
          if (w_wr_fin) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            case (r_state)
              S_IP_WR: r_state <= S_IP_B;
              S_AT_WR: r_state <= S_AT_RSP;
              default: r_state <= S_NT_B;
            endcase
          end
        end
        S_IP_B: begin
          if (w_b_hs) r_state <= (!w_b_err && w_ie_hit) ? S_NT_WR : S_IDLE;
        end
        S_AT_RSP: begin
          r_b_got <= w_at_b;
          r_r_got <= w_at_r;
          r_err   <= w_at_err;
          if (w_at_b && w_at_r) r_state <= w_at_err ? S_IDLE : S_IE_AR;
        end
        S_IE_AR: if (w_ar_hs) r_state <= S_IE_R;
        S_IE_R: begin
          if (w_r_hs) begin
            r_ie    <= mem_resp_i.r.data;
            r_state <= (!w_r_err && w_rd_hit) ? S_NT_WR : S_IDLE;
          end
        end
        S_NT_B:  if (w_b_hs) r_state <= S_IDLE;
        S_DRAIN: if (w_r_hs && mem_resp_i.r.last) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_iommu_mrif_engine.sv
// tb/tb_rv_iommu_mrif_engine.sv - directed bench for the MRIF engine (RMW and atomic builds)
module tb_rv_iommu_mrif_engine;

  logic clk;
  logic rst_n;
  logic init0, init1;
  logic [31:0] int_id;
  logic [46:0] mrif_addr;
  logic [10:0] notice_nid;
  logic [43:0] notice_ppn;
  rv_iommu::axi_rsp_t rsp;
  rv_iommu::axi_req_t req0, req1, rq;
  logic busy0, done0, ign0, err0, busy1, done1, ign1, err1;
  logic busy_s, done_s, ign_s, err_s;
  logic [rv_iommu::CAUSE_LEN-1:0] cause0, cause1, cause_s;
  bit sel;
  int n_assert;
  int n_fail;

  rv_iommu_mrif_engine #(
    .axi_req_t(rv_iommu::axi_req_t), .axi_rsp_t(rv_iommu::axi_rsp_t),
    .ID_BITS(11), .USE_ATOMIC(1'b0), .AR_ID(4'b0100), .AW_ID(4'b0011)
  ) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .mem_resp_i(rsp), .mem_req_o(req0),
    .init_mrif_i(init0), .int_id_i(int_id), .mrif_addr_i(mrif_addr),
    .notice_nid_i(notice_nid), .notice_ppn_i(notice_ppn),
    .busy_o(busy0), .done_o(done0), .ignore_o(ign0), .error_o(err0), .cause_o(cause0)
  );

  rv_iommu_mrif_engine #(
    .axi_req_t(rv_iommu::axi_req_t), .axi_rsp_t(rv_iommu::axi_rsp_t),
    .ID_BITS(6), .USE_ATOMIC(1'b1), .AR_ID(4'b0100), .AW_ID(4'b0011)
  ) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .mem_resp_i(rsp), .mem_req_o(req1),
    .init_mrif_i(init1), .int_id_i(int_id), .mrif_addr_i(mrif_addr),
    .notice_nid_i(notice_nid), .notice_ppn_i(notice_ppn),
    .busy_o(busy1), .done_o(done1), .ignore_o(ign1), .error_o(err1), .cause_o(cause1)
  );

  assign rq      = sel ? req1  : req0;
  assign busy_s  = sel ? busy1 : busy0;
  assign done_s  = sel ? done1 : done0;
  assign ign_s   = sel ? ign1  : ign0;
  assign err_s   = sel ? err1  : err0;
  assign cause_s = sel ? cause1 : cause0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input bit s, input logic [31:0] id, input bit exp_ign);
    sel = s;
    int_id = id;
    if (s) init1 = 1'b1; else init0 = 1'b1;
    #1;
    chk("start_ignore", ign_s, exp_ign);
    tick();
    init0 = 1'b0;
    init1 = 1'b0;
  endtask

  task automatic do_ar(input string tag, input logic [63:0] addr, input logic [7:0] len);
    int n = 0;
    #1;
    while (!rq.ar_valid && n < 20) begin tick(); #1; n++; end
    chk({tag, "_arvalid"}, rq.ar_valid, 1);
    chk({tag, "_araddr"}, rq.ar.addr, addr);
    chk({tag, "_arlen"}, {rq.ar.len, rq.ar.id}, {len, 4'b0100});
    rsp.ar_ready = 1'b1;
    tick();
    rsp.ar_ready = 1'b0;
  endtask

  task automatic do_r(input string tag, input logic [63:0] data, input logic [1:0] resp,
                      input bit last, input logic [1:0] de);
    int n = 0;
    rsp.r_valid = 1'b1;
    rsp.r.data = data;
    rsp.r.resp = resp;
    rsp.r.last = last;
    #1;
    while (!rq.r_ready && n < 20) begin tick(); #1; n++; end
    chk({tag, "_rready"}, rq.r_ready, 1);
    chk({tag, "_done_err"}, {done_s, err_s}, de);
    if (de[0]) chk({tag, "_cause"}, cause_s, 270);
    tick();
    rsp.r_valid = 1'b0;
  endtask

  task automatic do_b(input string tag, input logic [1:0] resp, input logic [1:0] de);
    int n = 0;
    rsp.b_valid = 1'b1;
    rsp.b.resp = resp;
    #1;
    while (!rq.b_ready && n < 20) begin tick(); #1; n++; end
    chk({tag, "_bready"}, rq.b_ready, 1);
    chk({tag, "_done_err"}, {done_s, err_s}, de);
    if (de[0]) chk({tag, "_cause"}, cause_s, 270);
    tick();
    rsp.b_valid = 1'b0;
  endtask

  task automatic do_aw_w(input string tag, input logic [63:0] addr, input logic [2:0] size,
                         input logic [63:0] data, input logic [7:0] strb,
                         input logic [5:0] atop, input int stall);
    int n = 0;
    #1;
    while (!rq.aw_valid && n < 20) begin tick(); #1; n++; end
    for (int i = 0; i <= stall; i++) begin
      chk({tag, "_valids"}, {rq.aw_valid, rq.w_valid, rq.w.last}, 3'b111);
      chk({tag, "_awaddr"}, rq.aw.addr, addr);
      chk({tag, "_awctl"}, {rq.aw.size, rq.aw.len, rq.aw.atop, rq.aw.id}, {size, 8'd0, atop, 4'b0011});
      chk({tag, "_wdata"}, rq.w.data, data);
      chk({tag, "_wstrb"}, rq.w.strb, strb);
      if (i < stall) begin tick(); #1; end
    end
    rsp.aw_ready = 1'b1;
    rsp.w_ready = 1'b1;
    tick();
    rsp.aw_ready = 1'b0;
    rsp.w_ready = 1'b0;
  endtask

  task automatic quiet(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      #1;
      chk(tag, {rq.ar_valid, rq.aw_valid, rq.w_valid, busy_s}, 4'b0000);
      tick();
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail = 0;
    sel = 1'b0;
    rst_n = 1'b0;
    init0 = 1'b0;
    init1 = 1'b0;
    int_id = '0;
    mrif_addr = 47'h1;
    notice_nid = 11'h2A5;
    notice_ppn = 44'h12345;
    rsp = '0;
    tick();
    tick();
    #1;
    chk("reset_status", {busy0, done0, ign0, err0, busy1, done1, ign1, err1}, 8'h00);
    chk("reset_axi", {req0.ar_valid, req0.aw_valid, req0.w_valid, req0.r_ready, req0.b_ready,
                      req1.ar_valid, req1.aw_valid, req1.w_valid, req1.r_ready, req1.b_ready}, 10'h000);
    rst_n = 1'b1;
    tick();

    // RMW flow with notice: id 70 -> group 1, bit 6
    start(1'b0, 32'd70, 1'b0);
    #1 chk("rmw_busy", busy0, 1);
    do_ar("rmw", 64'h210, 8'd1);
    do_r("rmw_ip", 64'h0, 2'b00, 1'b0, 2'b00);
    do_r("rmw_ie", 64'h40, 2'b00, 1'b1, 2'b00);
    do_aw_w("rmw_ipw", 64'h210, 3'd3, 64'h40, 8'hFF, 6'h00, 1);
    do_b("rmw_ipb", 2'b00, 2'b00);
    do_aw_w("rmw_ntc", 64'h12345000, 3'd2, 64'h2A5, 8'h0F, 6'h00, 0);
    do_b("rmw_ntb", 2'b00, 2'b10);

    // Back-to-back: IE bit clear, IP bits preserved, no notice
    start(1'b0, 32'd5, 1'b0);
    do_ar("ieclr", 64'h200, 8'd1);
    do_r("ieclr_ip", 64'h101, 2'b00, 1'b0, 2'b00);
    do_r("ieclr_ie", 64'h0, 2'b00, 1'b1, 2'b00);
    do_aw_w("ieclr_ipw", 64'h200, 3'd3, 64'h121, 8'hFF, 6'h00, 0);
    do_b("ieclr_ipb", 2'b00, 2'b10);
    quiet("ieclr_quiet", 3);

    // Invalid identities
    start(1'b0, 32'h800, 1'b1);
    quiet("id800_quiet", 2);
    start(1'b0, 32'h0, 1'b1);
    quiet("id0_quiet", 2);

    // R error on beat 0: drain beat 1, no write
    start(1'b0, 32'd70, 1'b0);
    do_ar("rerr", 64'h210, 8'd1);
    do_r("rerr_b0", 64'h0, 2'b10, 1'b0, 2'b01);
    #1 chk("rerr_drain_busy", busy0, 1);
    do_r("rerr_b1", 64'h0, 2'b00, 1'b1, 2'b00);
    quiet("rerr_quiet", 3);

    // Reset mid-transaction abandons the request
    start(1'b0, 32'd5, 1'b0);
    do_ar("rst", 64'h200, 8'd1);
    rst_n = 1'b0;
    #1 chk("rst_mid", {busy0, done0, err0, req0.r_ready}, 4'b0000);
    tick();
    rst_n = 1'b1;
    tick();

    // ID_BITS=6, atomic build
    mrif_addr = 47'h3;
    start(1'b1, 32'd64, 1'b1);
    quiet("id64_quiet", 2);

    // Atomic: AW stalled 5 cycles, R before B, IE clear
    start(1'b1, 32'd45, 1'b0);
    do_aw_w("at", 64'h600, 3'd3, 64'h0000_2000_0000_0000, 8'hFF, 6'h23, 5);
    do_r("at_r", 64'h5, 2'b00, 1'b1, 2'b00);
    do_b("at_b", 2'b00, 2'b00);
    do_ar("at_ie", 64'h608, 8'd0);
    do_r("at_ier", 64'h0, 2'b00, 1'b1, 2'b10);
    quiet("at_quiet", 2);

    // Atomic: B error first, R still consumed, no IE read
    start(1'b1, 32'd45, 1'b0);
    do_aw_w("aterr", 64'h600, 3'd3, 64'h0000_2000_0000_0000, 8'hFF, 6'h23, 0);
    do_b("aterr_b", 2'b10, 2'b01);
    #1 chk("aterr_busy", busy1, 1);
    do_r("aterr_r", 64'h0, 2'b00, 1'b1, 2'b00);
    quiet("aterr_quiet", 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
